// File: rtl/scalar_pkg.sv
// Shared sizing constants for the scalar register file and its
// per-register writeback scoreboard.
package scalar_pkg;
  localparam int N        = 32;
  localparam int NREG     = 16;
  localparam int AW       = $clog2(NREG);
  localparam int PW       = 2;
  localparam logic [PW-1:0] PEND_MAX = '1;
endpackage

// File: rtl/sb_counter.sv
// Next-state logic for one register's in-flight writeback counter:
// saturating increment on issue, guarded decrement on writeback.
module sb_counter
  import scalar_pkg::*;
(
  input  logic [PW-1:0] pend_q,
  input  logic          inc,
  input  logic          dec,
  output logic [PW-1:0] pend_d,
  output logic [PW-1:0] eff,
  output logic          underflow
);

  // A writeback landing this cycle already satisfies one pending producer.
  // Kept separate from the update logic so the stall path never depends on inc.
  assign eff = (dec && pend_q != '0) ? pend_q - 1'b1 : pend_q;

  always_comb begin
    pend_d    = pend_q;
    underflow = 1'b0;
    if (inc && !dec) begin
      if (pend_q != PEND_MAX) pend_d = pend_q + 1'b1;
    end else if (dec && !inc) begin
      if (pend_q == '0) underflow = 1'b1;
      else              pend_d    = pend_q - 1'b1;
    end
  end

endmodule

// File: rtl/scalar_regfile_wb.sv
// Scalar register file (R0 hardwired to zero) with writeback bypass and a
// pending-write scoreboard that stalls issue on RAW hazards.
module scalar_regfile_wb #(
  parameter  int N    = scalar_pkg::N,
  parameter  int NREG = scalar_pkg::NREG,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  input  logic          Use1,
  input  logic          Use2,
  output logic [N-1:0]  RD1,
  output logic [N-1:0]  RD2,
  input  logic [AW-1:0] A3,
  input  logic          WE3,
  input  logic [N-1:0]  WD3_SCA,
  input  logic          Issue_Valid,
  input  logic          Issue_WritesReg,
  input  logic [AW-1:0] Issue_Dest,
  output logic          Stall,
  output logic          Err
);
  import scalar_pkg::*;

  logic [N-1:0]  regs_q [NREG];
  logic [N-1:0]  regs_d [NREG];
  logic [PW-1:0] pend_q [NREG];
  logic [PW-1:0] pend_d [NREG];
  logic [PW-1:0] eff    [NREG];
  logic [NREG-1:0] underflow;
  logic err_q, err_d;
  logic wb_fire, issue_fire;
  logic stall_c;

  assign wb_fire    = WE3 && (A3 != '0);
  assign issue_fire = Issue_Valid && Issue_WritesReg && !stall_c && (Issue_Dest != '0);

  assign pend_d[0]    = '0;
  assign eff[0]       = '0;
  assign underflow[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_pend
      sb_counter u_cnt (
        .pend_q    (pend_q[gi]),
        .inc       (issue_fire && (Issue_Dest == AW'(gi))),
        .dec       (wb_fire && (A3 == AW'(gi))),
        .pend_d    (pend_d[gi]),
        .eff       (eff[gi]),
        .underflow (underflow[gi])
      );
    end
  endgenerate

  always_comb begin
    stall_c = 1'b0;
    if (Issue_Valid) begin
      if (Use1 && (A1 != '0) && (eff[A1] != '0)) stall_c = 1'b1;
      if (Use2 && (A2 != '0) && (eff[A2] != '0)) stall_c = 1'b1;
      // Saturated counter: issuing again would lose track of a producer.
      if (Issue_WritesReg && (Issue_Dest != '0) && (pend_q[Issue_Dest] == PEND_MAX))
        stall_c = 1'b1;
    end
  end

  assign Stall = stall_c;
  assign Err   = err_q;

  assign RD1 = (A1 == '0)                ? '0      :
               (wb_fire && (A3 == A1))   ? WD3_SCA : regs_q[A1];
  assign RD2 = (A2 == '0)                ? '0      :
               (wb_fire && (A3 == A2))   ? WD3_SCA : regs_q[A2];

  always_comb begin
    regs_d = regs_q;
    if (wb_fire) regs_d[A3] = WD3_SCA;
    err_d = err_q | (|underflow);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        pend_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_scalar_regfile_wb.sv
// Directed bench: stimulus queues expected values, a negedge monitor
// drains the queue and compares against live DUT outputs.
module tb_scalar_regfile_wb;
  localparam int N  = 32;
  localparam int AW = 4;

  localparam int K_RD1 = 0, K_RD2 = 1, K_STALL = 2, K_ERR = 3, K_PEND = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] A1, A2, A3, Issue_Dest;
  logic          Use1, Use2, WE3, Issue_Valid, Issue_WritesReg;
  logic [N-1:0]  WD3_SCA, RD1, RD2;
  logic          Stall, Err;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } chk_t;

  chk_t sbq[$];
  int n_checks = 0;
  int n_fail   = 0;

  scalar_regfile_wb dut (
    .clk(clk), .rst(rst),
    .A1(A1), .A2(A2), .Use1(Use1), .Use2(Use2),
    .RD1(RD1), .RD2(RD2),
    .A3(A3), .WE3(WE3), .WD3_SCA(WD3_SCA),
    .Issue_Valid(Issue_Valid), .Issue_WritesReg(Issue_WritesReg), .Issue_Dest(Issue_Dest),
    .Stall(Stall), .Err(Err)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string name, input int kind, input int idx, input logic [31:0] exp);
    chk_t e;
    e.name = name; e.kind = kind; e.idx = idx; e.exp = exp;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] actual(input int kind, input int idx);
    case (kind)
      K_RD1:   return RD1;
      K_RD2:   return RD2;
      K_STALL: return {31'b0, Stall};
      K_ERR:   return {31'b0, Err};
      default: return {30'b0, dut.pend_q[idx]};
    endcase
  endfunction

  always @(negedge clk) begin
    chk_t e;
    logic [31:0] a;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = actual(e.kind, e.idx);
      n_checks++;
      if (a !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, a, e.exp);
      end else begin
        $display("ok   %s: 0x%08h", e.name, a);
      end
    end
  end

  task automatic idle_in();
    A1 = '0; A2 = '0; A3 = '0; Issue_Dest = '0;
    Use1 = 0; Use2 = 0; WE3 = 0; Issue_Valid = 0; Issue_WritesReg = 0;
    WD3_SCA = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic issue(input logic [AW-1:0] dest);
    Issue_Valid = 1; Issue_WritesReg = 1; Issue_Dest = dest;
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [N-1:0] d);
    WE3 = 1; A3 = a; WD3_SCA = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_in();
    A1 = 4'd5; A2 = 4'd7;
    #1;
    n_checks++;
    if (RD1 !== 32'h0) begin
      n_fail++;
      $display("FAIL inline_reset_rd1: got 0x%08h, expected 0x00000000", RD1);
    end else begin
      $display("ok   inline_reset_rd1: 0x%08h", RD1);
    end
    n_checks++;
    if (RD2 !== 32'h0) begin
      n_fail++;
      $display("FAIL inline_reset_rd2: got 0x%08h, expected 0x00000000", RD2);
    end else begin
      $display("ok   inline_reset_rd2: 0x%08h", RD2);
    end
    expect_val("reset_rd1", K_RD1, 0, 32'h0);
    expect_val("reset_rd2", K_RD2, 0, 32'h0);
    expect_val("reset_stall", K_STALL, 0, 32'h0);
    expect_val("reset_err", K_ERR, 0, 32'h0);
    cyc();

    cyc(); rst = 1'b0;
    wb(4'd5, 32'hDEADBEEF);
    expect_val("err_before_underflow", K_ERR, 0, 32'h0);
    cyc();
    wb(4'd0, 32'h00000001); A1 = 4'd5; A2 = 4'd0;
    expect_val("read_r5", K_RD1, 0, 32'hDEADBEEF);
    expect_val("read_r0_during_w0", K_RD2, 0, 32'h0);
    expect_val("err_after_underflow", K_ERR, 0, 32'h1);
    cyc();
    wb(4'd7, 32'h12345678); A2 = 4'd7; A1 = 4'd0;
    #1;
    n_checks++;
    if (RD2 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL inline_bypass_rd2: got 0x%08h, expected 0x12345678", RD2);
    end else begin
      $display("ok   inline_bypass_rd2: 0x%08h", RD2);
    end
    expect_val("bypass_rd2", K_RD2, 0, 32'h12345678);
    expect_val("read_r0_after_w0", K_RD1, 0, 32'h0);
    cyc();
    A1 = 4'd5; A2 = 4'd7;
    expect_val("stored_r7", K_RD2, 0, 32'h12345678);
    expect_val("stored_r5", K_RD1, 0, 32'hDEADBEEF);

    cyc(); rst = 1'b1;
    wb(4'd8, 32'hAAAA5555); A1 = 4'd5; A2 = 4'd7;
    expect_val("rst_clears_r5", K_RD1, 0, 32'h0);
    expect_val("rst_clears_r7", K_RD2, 0, 32'h0);
    expect_val("rst_clears_err", K_ERR, 0, 32'h0);
    cyc(); rst = 1'b0;
    A1 = 4'd8;
    expect_val("write_during_rst_dropped", K_RD1, 0, 32'h0);

    cyc(); issue(4'd3);
    expect_val("issue3_no_stall", K_STALL, 0, 32'h0);
    cyc(); Issue_Valid = 1; Use1 = 1; A1 = 4'd3;
    expect_val("raw_r3_stall", K_STALL, 0, 32'h1);
    expect_val("pend3_is1", K_PEND, 3, 32'd1);
    cyc(); Issue_Valid = 1; Use1 = 1; A1 = 4'd3; wb(4'd3, 32'hCAFEF00D);
    expect_val("raw_r3_wb_release", K_STALL, 0, 32'h0);
    expect_val("raw_r3_bypass", K_RD1, 0, 32'hCAFEF00D);
    cyc();
    expect_val("pend3_cleared", K_PEND, 3, 32'd0);
    expect_val("err_clean_r3", K_ERR, 0, 32'h0);

    for (int i = 0; i < 3; i++) begin
      cyc(); issue(4'd4);
      expect_val($sformatf("issue4_%0d_no_stall", i), K_STALL, 0, 32'h0);
    end
    cyc(); issue(4'd4);
    expect_val("issue4_sat_stall", K_STALL, 0, 32'h1);
    expect_val("pend4_sat", K_PEND, 4, 32'd3);
    cyc();
    expect_val("pend4_held", K_PEND, 4, 32'd3);
    for (int i = 0; i < 3; i++) begin
      cyc(); wb(4'd4, 32'h40 + 32'(i));
      expect_val($sformatf("pend4_drain_%0d", i), K_PEND, 4, 32'(3 - i));
    end
    cyc();
    expect_val("pend4_empty", K_PEND, 4, 32'd0);
    expect_val("err_clean_r4", K_ERR, 0, 32'h0);

    cyc(); issue(4'd6);
    cyc(); issue(4'd6); wb(4'd6, 32'h00000066);
    expect_val("simul6_no_stall", K_STALL, 0, 32'h0);
    cyc();
    expect_val("pend6_unchanged", K_PEND, 6, 32'd1);
    expect_val("err_before_r9", K_ERR, 0, 32'h0);
    cyc(); wb(4'd9, 32'h99);
    expect_val("pend9_zero", K_PEND, 9, 32'd0);
    cyc();
    expect_val("err_r9_underflow", K_ERR, 0, 32'h1);
    expect_val("pend9_no_wrap", K_PEND, 9, 32'd0);

    cyc(); issue(4'd2);
    cyc(); issue(4'd2);
    cyc(); Issue_Valid = 1; Use1 = 1; A1 = 4'd6;
    expect_val("pend2_is2", K_PEND, 2, 32'd2);
    expect_val("pre_rst_stall_r6", K_STALL, 0, 32'h1);
    expect_val("pre_rst_r6", K_RD1, 0, 32'h00000066);
    cyc(); Issue_Valid = 1; Use1 = 1; A1 = 4'd6;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (dut.pend_q[2] !== 2'd0) begin
      n_fail++;
      $display("FAIL inline_async_rst_pend2: got %0d, expected 0", dut.pend_q[2]);
    end else begin
      $display("ok   inline_async_rst_pend2: %0d", dut.pend_q[2]);
    end
    n_checks++;
    if (Err !== 1'b0) begin
      n_fail++;
      $display("FAIL inline_async_rst_err: got %0b, expected 0", Err);
    end else begin
      $display("ok   inline_async_rst_err: %0b", Err);
    end
    n_checks++;
    if (RD1 !== 32'h0) begin
      n_fail++;
      $display("FAIL inline_async_rst_r6: got 0x%08h, expected 0x00000000", RD1);
    end else begin
      $display("ok   inline_async_rst_r6: 0x%08h", RD1);
    end
    expect_val("async_rst_pend2", K_PEND, 2, 32'd0);
    expect_val("async_rst_pend6", K_PEND, 6, 32'd0);
    expect_val("async_rst_err", K_ERR, 0, 32'h0);
    expect_val("async_rst_r6", K_RD1, 0, 32'h0);
    expect_val("async_rst_stall", K_STALL, 0, 32'h0);
    cyc(); rst = 1'b0;
    cyc();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
